// File: rtl/dmem_mmio.sv
// rtl/dmem_mmio.sv - data-side memory responder: word RAM, cycle counter/compare, byte TX FIFO
module dmem_mmio #(
   parameter int DEPTH_WORDS = 64,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwrite,
   input  logic [31:0] addr,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        misaligned,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        irq
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [31:0] A_CYCLE  = 32'hFFFF_FF00;
   localparam logic [31:0] A_CMP    = 32'hFFFF_FF04;
   localparam logic [31:0] A_STATUS = 32'hFFFF_FF08;
   localparam logic [31:0] A_TXDATA = 32'hFFFF_FF0C;
   localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

   logic          aligned, we;
   logic          ram_sel, cyc_sel, cmp_sel, stat_sel, tx_sel;
   logic [31:0]   ram [DEPTH_WORDS];
   logic [31:0]   cycle, cmp;
   logic          match, overflow;
   logic [7:0]    fifo [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [PW:0]   count;
   logic          full, empty, pop, push_req, push, match_set;

   assign aligned    = (addr[1:0] == 2'b00);
   assign misaligned = ~aligned;
   assign we         = memwrite & aligned;
   assign ram_sel    = (addr[31:AW+2] == '0);
   assign cyc_sel    = (addr == A_CYCLE);
   assign cmp_sel    = (addr == A_CMP);
   assign stat_sel   = (addr == A_STATUS);
   assign tx_sel     = (addr == A_TXDATA);

   assign full      = (count == FULL_CNT);
   assign empty     = (count == '0);
   assign pop       = ~empty & tx_ready;
   assign push_req  = we & tx_sel;
   // A full FIFO still accepts a byte when the head leaves on the same edge.
   assign push      = push_req & (~full | pop);
   assign match_set = (cycle == cmp) && (cmp != 32'd0);

   assign tx_valid = ~empty;
   assign tx_data  = empty ? 8'h00 : fifo[rd_ptr];
   assign irq      = match;

   always_ff @(posedge clk) begin
      if (!reset && we && ram_sel)
         ram[addr[AW+1:2]] <= writedata;
   end

   always_ff @(posedge clk) begin
      if (!reset && push)
         fifo[wr_ptr] <= writedata[7:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cycle    <= 32'd0;
         cmp      <= 32'd0;
         match    <= 1'b0;
         overflow <= 1'b0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         cycle <= (we && cyc_sel) ? 32'd0 : cycle + 32'd1;
         if (we && cmp_sel)
            cmp <= writedata;
         // Setting takes priority over a write-one-to-clear on the same edge.
         match    <= match_set | (match & ~(we & stat_sel & writedata[2]));
         overflow <= (push_req & ~push) | (overflow & ~(we & stat_sel & writedata[3]));
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      readdata = 32'd0;
      if (aligned) begin
         if (ram_sel)
            readdata = ram[addr[AW+1:2]];
         else if (cyc_sel)
            readdata = cycle;
         else if (cmp_sel)
            readdata = cmp;
         else if (stat_sel)
            readdata = {28'd0, overflow, match, empty, full};
         else if (tx_sel)
            readdata = {{(31-PW){1'b0}}, count};
      end
   end
endmodule

// File: doc/dmem_mmio.md
# dmem_mmio

Data-side memory responder for the single-cycle MIPS core. Sits on the core's data port: it takes the ALU result as the address, plus `writedata` and `memwrite`, and returns `readdata` in the same cycle. It contains word RAM, a free-running cycle counter with compare/interrupt, and a byte transmit FIFO drained by a valid/ready handshake.

## Interface
- `DEPTH_WORDS`, 64: RAM size in 32-bit words; power of two, 16 to 1024.
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, 2 to 64.

- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `memwrite`  in  1  write strobe from the core.
- `addr`  in  32  byte address (core ALU result).
- `writedata`  in  32  store data.
- `readdata`  out  32  load data, combinational from `addr` and current state.
- `misaligned`  out  1  combinational; high when `addr[1:0] != 0`.
- `tx_data`  out  8  FIFO head byte.
- `tx_valid`  out  1  FIFO not empty.
- `tx_ready`  in  1  consumer accepts the head this cycle.
- `irq`  out  1  equals STATUS.match.

## Operation
- Address map; word-aligned accesses only:
  - RAM: `0x0000_0000` to `DEPTH_WORDS*4-1`. Index is `addr[log2(DEPTH_WORDS)+1:2]`.
  - CYCLE `0xFFFF_FF00`: read returns the counter. Any write clears it to 0.
  - CMP `0xFFFF_FF04`: read/write compare value.
  - STATUS `0xFFFF_FF08`: read-only fields except the sticky bits.
    - bit0 fifo_full, bit1 fifo_empty, bit2 match (sticky), bit3 overflow (sticky).
    - Writing 1 to bit2 or bit3 clears that bit. Other bits ignore writes.
  - TXDATA `0xFFFF_FF0C`: write pushes `writedata[7:0]`. Read returns the FIFO occupancy, zero-extended.
  - Any other address reads 0 and ignores writes.
- Misaligned access: read returns 0, write is ignored, `misaligned` is 1. The state is not otherwise flagged.
- RAM: synchronous write on the edge when `memwrite=1`. Asynchronous read. RAM contents are not reset.
- Cycle counter: 32-bit. Increments by 1 every cycle and wraps from `0xFFFF_FFFF` to 0. A CYCLE write on an edge loads 0 instead of incrementing.
- Match: on any edge where the pre-edge counter equals CMP and CMP != 0, STATUS.match is set.
  - If a set and a W1C clear happen on the same edge, set wins.
  - CMP = 0 disables matching.
- FIFO:
  - `tx_valid` = !empty; `tx_data` = head.
  - Pop occurs on an edge with `tx_valid & tx_ready`.
  - Push occurs on a TXDATA write when not full, or when full and a pop happens on the same edge.
  - A push that is refused sets overflow; the byte is dropped.
  - Pointers wrap modulo `FIFO_DEPTH`. Occupancy ranges 0 to `FIFO_DEPTH`.
- Only one register or RAM word is written per cycle.

## Timing
- Reset values:
  - `readdata` follows the map; CYCLE reads 0 during reset.
  - CMP = 0, STATUS sticky bits = 0, FIFO empty.
  - `tx_valid` = 0, `tx_data` = 0, `irq` = 0.
  - RAM is untouched.
- Read latency is 0 cycles, combinational, so it fits the single-cycle core.
- Write effect is visible to reads in the cycle after the write edge.
- `irq` rises one cycle after the cycle in which counter == CMP.
- A pushed byte appears on `tx_valid`/`tx_data` the cycle after the push edge.
- A byte is held stable while `tx_valid=1` and `tx_ready=0`.
- Reset asserted mid-operation:
  - FIFO empties and counter clears immediately (asynchronously).
  - A write in progress on that edge is discarded.

## Test plan
1. Write `0xDEADBEEF` to `0x10`, then read `0x10` → `readdata=0xDEADBEEF`. Read `0x12` → 0 and `misaligned=1`.
2. Release reset, wait 5 cycles, read CYCLE → 5. Write CYCLE, then on the next cycle read → 0.
3. Write CMP=20 after reset → `irq` rises the cycle after the counter reads 20 and stays high. Write STATUS `0x4` → `irq` falls next cycle.
4. With `tx_ready=0`, push `0x41` through `0x48` (8 bytes) → STATUS full=1 and TXDATA reads 8. A 9th push → overflow=1, occupancy stays 8.
5. Raise `tx_ready` → `0x41` through `0x48` leave in order, one per cycle. `tx_valid` drops after the last byte; empty=1.
6. FIFO full, push `0x55` with `tx_ready=1` on the same edge → pop and push both occur, occupancy stays 8, no overflow. Assert reset mid-drain → `tx_valid=0` immediately.
